// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 32-bit ALU: decodes RV32I OP/OP-IMM into G_sel/A/B
// and holds them in a main register backed by a one-entry skid register.
module alu_issue_stage #(
    parameter int unsigned COUNT_W    = 16,
    parameter bit          SHAMT_MASK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic               in_is_imm,
    input  logic [31:0]        in_rs1_val,
    input  logic [31:0]        in_rs2_val,
    input  logic [31:0]        in_imm,
    input  logic [4:0]         in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         G_sel,
    output logic [31:0]        A,
    output logic [31:0]        B,
    output logic [4:0]         out_rd,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] issue_count
);

    typedef struct packed {
        logic [3:0]  gsel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    entry_t             w_new;
    entry_t             r_main;
    entry_t             r_skid;
    logic               r_m_valid;
    logic               r_s_valid;
    logic               w_accept;
    logic               w_drain;
    logic               w_shift;
    logic               w_ill;
    logic               w_f7_zero;
    logic               w_f7_alt;
    logic [31:0]        w_bsel;
    logic [COUNT_W-1:0] r_count;

    assign w_f7_zero = (in_funct7 == 7'h00);
    assign w_f7_alt  = (in_funct7 == 7'h20);
    assign w_shift   = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign w_bsel    = in_is_imm ? in_imm : in_rs2_val;

    always_comb begin
        w_ill = 1'b0;
        if (!in_is_imm && !w_f7_zero && !w_f7_alt)
            w_ill = 1'b1;
        if (!in_is_imm && w_f7_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101))
            w_ill = 1'b1;
        if ((in_funct3 == 3'b001) && !w_f7_zero)
            w_ill = 1'b1;
        if ((in_funct3 == 3'b101) && !w_f7_zero && !w_f7_alt)
            w_ill = 1'b1;
    end

    always_comb begin
        w_new     = '0;
        w_new.rd  = in_rd;
        w_new.ill = w_ill;
        if (!w_ill) begin
            w_new.gsel[3:1] = in_funct3;
            // Only SUB and SRA/SRAI use funct7[5] as the low select bit.
            if ((in_funct3 == 3'b101) || ((in_funct3 == 3'b000) && !in_is_imm))
                w_new.gsel[0] = in_funct7[5];
            w_new.a = in_rs1_val;
            if (SHAMT_MASK && w_shift)
                w_new.b = {27'd0, w_bsel[4:0]};
            else
                w_new.b = w_bsel;
        end
    end

    assign in_ready = ~r_s_valid;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_m_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_main    <= '0;
            r_skid    <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid || out_ready) begin
            // Skid is only ever valid while in_ready is low, so it never races a new accept.
            if (r_s_valid) begin
                r_main    <= r_skid;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_main    <= w_new;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid    <= w_new;
            r_s_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (w_drain)
            r_count <= r_count + 1'b1;
    end

    assign out_valid   = r_m_valid;
    assign G_sel       = r_main.gsel;
    assign A           = r_main.a;
    assign B           = r_main.b;
    assign out_rd      = r_main.rd;
    assign out_illegal = r_main.ill;
    assign issue_count = r_count;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue pipeline stage directly upstream of the 32-bit combinational ALU. Accepts RV32I OP/OP-IMM fields plus operand values over a valid/ready handshake and translates funct3/funct7 into the ALU's 4-bit G_sel. Presents registered, stable G_sel/A/B to the ALU until the downstream consumer accepts them. Includes a 2-entry skid buffer, so in_ready is a registered signal and full throughput is kept under backpressure.

Parameters:
COUNT_W, 16, width of the issued-operation counter
SHAMT_MASK, 1, 1 = force B[31:5] to zero for SLL/SRL/SRA; 0 = pass B unmodified

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept; registered
in_funct3  input  3  RV32I funct3
in_funct7  input  7  RV32I funct7 (for OP-IMM: imm[11:5])
in_is_imm  input  1  1 = OP-IMM, B taken from in_imm
in_rs1_val  input  32  rs1 operand
in_rs2_val  input  32  rs2 operand
in_imm  input  32  sign-extended immediate
in_rd  input  5  destination register tag
out_valid  output  1  G_sel/A/B/out_rd valid
out_ready  input  1  downstream accepts
G_sel  output  4  ALU operation select
A  output  32  ALU operand A
B  output  32  ALU operand B
out_rd  output  5  destination tag, travels with the operation
out_illegal  output  1  decoded encoding is not a legal ALU op
issue_count  output  COUNT_W  number of accepted output transfers, wraps

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, G_sel=0, A=0, B=0, out_rd=0, out_illegal=0, issue_count=0, both buffer entries empty.
- Decode: G_sel = {funct3, s}. s = funct7[5] when funct3=101, or when funct3=000 and in_is_imm=0; otherwise s=0. The resulting codes are ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Illegal: R-type with funct7 not 0x00/0x20; R-type funct7=0x20 with funct3 not 000/101; any funct3=001 with funct7≠0; funct3=101 with funct7 not 0x00/0x20 (applies to immediate shifts too). Illegal entries still flow through with out_illegal=1, G_sel=0000, A=0, B=0, out_rd passed.
- Operands: A=rs1_val; B=in_is_imm ? imm : rs2_val. If SHAMT_MASK=1 and the op is a shift, B = {27'b0, B[4:0]}.
- Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. Latency is 1 cycle from input transfer to out_valid, with no bubbles when out_ready is held high.
- Skid buffer: main register drives the outputs; a skid register captures an accepted entry when the main register is valid and not draining. in_ready = !skid_valid (registered). Order is strictly FIFO.
- When the output drains, skid moves to main, or a new input loads main. A simultaneous drain and accept with skid empty loads main directly.
- Outputs stay stable while out_valid=1 and out_ready=0.
- issue_count increments by 1 on each output transfer and wraps at 2^COUNT_W to 0.
- flush: next cycle out_valid=0, skid empty, in_ready=1. An input presented in the flush cycle is dropped. A transfer in the flush cycle still counts. Flush has priority over every other update.
- Reset mid-transfer: all state clears immediately; no partial entry survives.

Test Plan:
- funct3=000, funct7=0x20, R-type, rs1=10, rs2=3, out_ready=1 -> one cycle later out_valid=1, G_sel=0001, A=10, B=3, issue_count goes 0→1.
- OP-IMM funct3=000, imm=0xFFFFFFFF, funct7=0x7F -> G_sel=0000 (ADDI, funct7 ignored), B=0xFFFFFFFF, out_illegal=0.
- R-type funct3=101, funct7=0x20, rs2=0x00000124 -> G_sel=1011, B=0x00000004; with funct7=0x01 -> out_illegal=1, G_sel=0000, A=B=0.
- Stream 4 ops with out_ready=0 -> first two buffered, in_ready drops to 0 after the second accept. Raise out_ready -> outputs appear in order ops 1,2,3,4 with no duplicates or losses, issue_count=4.
- With main and skid full, assert flush -> next cycle out_valid=0 and in_ready=1, issue_count unchanged, later input issues normally.
- Drop rst_n asynchronously mid-stream (between clock edges) -> all outputs read reset values before the next edge. Set COUNT_W=2 and issue 5 ops -> issue_count=1.
